// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmit buffer: status/control
// bit positions, FSM state encoding and the status word packer.
package uart_pkg;

    localparam int STAT_BUSY  = 31;
    localparam int STAT_OVF   = 30;
    localparam int STAT_FULL  = 29;
    localparam int STAT_EMPTY = 28;

    localparam int CTRL_BIT     = 31;
    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_state_e;

    function automatic logic [31:0] pack_status(input logic busy, input logic ovf,
                                                input logic full, input logic empty,
                                                input logic [15:0] cnt);
        logic [31:0] word;
        word             = 32'h0;
        word[STAT_BUSY]  = busy;
        word[STAT_OVF]   = ovf;
        word[STAT_FULL]  = full;
        word[STAT_EMPTY] = empty;
        word[15:0]       = cnt;
        return word;
    endfunction

endpackage

// File: rtl/uart_tx_mem_if.sv
// Store/status bus on the CPU side plus the handshake towards the uart_tx serializer.
interface uart_tx_mem_if;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic        tx_empty;

    modport master (
        output mem_wen, mem_wdata, tx_active, tx_done,
        input  mem_rdata, tx_dv, tx_byte, tx_empty
    );

    modport slave (
        input  mem_wen, mem_wdata, tx_active, tx_done,
        output mem_rdata, tx_dv, tx_byte, tx_empty
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmit FSM; dout is the head registered at pop time.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty
);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    // Storage carries no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= 8'h00;
        end else begin
            if (pop_ok) dout <= mem[rd_ptr];
            // The head is latched above even when flushing, so the popped byte survives.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_tx_mem.sv
// Memory-mapped UART transmit buffer: CPU stores fill a FIFO, a small FSM hands
// one byte per frame to uart_tx, and loads return busy/overflow/full/empty/count.
module uart_tx_mem
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mem_if.slave  bus
);
    tx_state_e        state;
    tx_state_e        state_n;
    logic             pop;
    logic             tx_dv;
    logic             tx_dv_n;
    logic             overflow;
    logic             is_ctrl;
    logic             push;
    logic             flush;
    logic             clr_ovf;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] count;
    logic [7:0]       head;
    logic             unused_wdata;

    assign is_ctrl      = bus.mem_wdata[CTRL_BIT];
    assign push         = bus.mem_wen && !is_ctrl;
    assign flush        = bus.mem_wen && is_ctrl && bus.mem_wdata[CTRL_FLUSH];
    assign clr_ovf      = bus.mem_wen && is_ctrl && bus.mem_wdata[CTRL_CLR_OVF];
    assign unused_wdata = ^bus.mem_wdata[30:8];

    uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (bus.mem_wdata[7:0]),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Waiting for tx_active low in IDLE keeps us off a serializer still busy from before a reset.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !bus.tx_active) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START:   state_n = WAIT;
            WAIT:    if (bus.tx_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        tx_dv_n = (state_n == START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx_dv <= 1'b0;
        end else begin
            state <= state_n;
            tx_dv <= tx_dv_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              overflow <= 1'b0;
        else if (clr_ovf)                     overflow <= 1'b0;
        else if (push && fifo_full && !pop)   overflow <= 1'b1;
    end

    assign bus.tx_dv     = tx_dv;
    assign bus.tx_byte   = head;
    assign bus.tx_empty  = fifo_empty && (state == IDLE);
    assign bus.mem_rdata = pack_status(state != IDLE, overflow, fifo_full, fifo_empty,
                                       16'(count));
endmodule

// File: tb/tb_uart_tx_mem.sv
// Bench for uart_tx_mem: a behavioural serializer, a queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_uart_tx_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_mem_if bus();

    uart_tx_mem #(.FIFO_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Serializer stand-in: frame starts on tx_dv, ends with a one-cycle tx_done; no reset.
    int ser_cnt   = 0;
    int frame_len = 4;
    bit rand_len  = 1'b0;
    bit stall     = 1'b0;

    initial begin
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) bus.tx_done = 1'b1;
            end else if (bus.tx_dv) begin
                ser_cnt = rand_len ? int'($urandom_range(2, 10)) : frame_len;
            end
            bus.tx_active = (ser_cnt > 0) || stall;
        end
    end

    // Reference model: queue of accepted bytes plus the byte currently on the line.
    logic [7:0] m_q[$];
    logic [7:0] m_byte;
    bit         m_inflight;
    bit         m_dv;
    bit         m_ovf;
    logic [7:0] sent[$];

    task automatic m_reset();
        m_q.delete();
        m_byte     = 8'h00;
        m_inflight = 1'b0;
        m_dv       = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic m_step();
        bit do_pop;
        bit done;
        do_pop = !m_inflight && (m_q.size() > 0) && !bus.tx_active;
        done   = m_inflight && !m_dv && bus.tx_done;
        if (done) m_inflight = 1'b0;
        if (do_pop) begin
            m_byte     = m_q.pop_front();
            m_inflight = 1'b1;
        end
        m_dv = do_pop;
        if (bus.mem_wen) begin
            if (!bus.mem_wdata[31]) begin
                if (m_q.size() < 16) m_q.push_back(bus.mem_wdata[7:0]);
                else                 m_ovf = 1'b1;
            end else begin
                if (bus.mem_wdata[0]) m_ovf = 1'b0;
                if (bus.mem_wdata[1]) m_q.delete();
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else     m_step();
        end
    end

    // Per-cycle comparison against the model, plus the tx_dv/tx_active protocol rule.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("status", bus.mem_rdata,
                    {m_inflight, m_ovf, m_q.size() == 16, m_q.size() == 0, 12'h0,
                     16'(m_q.size())});
                chk("tx_dv", 32'(bus.tx_dv), 32'(m_dv));
                chk("tx_empty", 32'(bus.tx_empty), 32'(m_q.size() == 0 && !m_inflight));
                if (m_inflight) chk("tx_byte", 32'(bus.tx_byte), 32'(m_byte));
                chk("dv_while_active", 32'(bus.tx_dv & bus.tx_active), 32'd0);
                if (bus.tx_dv) sent.push_back(bus.tx_byte);
            end
        end
    end

    task automatic wr(input logic [31:0] d);
        @(negedge clk);
        bus.mem_wen   = 1'b1;
        bus.mem_wdata = d;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = 32'h0;
    endtask

    task automatic set_stall(input bit s);
        @(posedge clk);
        #2;
        stall = s;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #2;
            if (bus.tx_empty && !bus.tx_active) break;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_empty: still busy after %0d cycles", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] r;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_status", bus.mem_rdata, 32'h1000_0000);
        chk("rst_tx_dv", 32'(bus.tx_dv), 32'd0);
        chk("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        chk("rst_tx_byte", 32'(bus.tx_byte), 32'h00);

        // Single byte: tx_dv two cycles after the store
        frame_len = 4;
        wr(32'h0000_0041);
        idle();
        @(posedge clk);
        #1;
        chk("single_dv", 32'(bus.tx_dv), 32'd1);
        chk("single_byte", 32'(bus.tx_byte), 32'h41);
        wait_empty(100);
        chk("single_done_status", bus.mem_rdata, 32'h1000_0000);
        chk("single_done_empty", 32'(bus.tx_empty), 32'd1);

        // Fill to full while stalled, overflow on the 17th, drain in order
        set_stall(1'b1);
        sent.delete();
        for (int i = 0; i < 16; i++) wr(32'h30 + 32'(i));
        idle();
        chk("full_status", bus.mem_rdata, 32'h2000_0010);
        wr(32'h0000_0040);
        idle();
        chk("ovf_status", bus.mem_rdata, 32'h6000_0010);
        set_stall(1'b0);
        wait_empty(600);
        chk("drain_count", 32'(sent.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk("drain_order", (i < sent.size()) ? 32'(sent[i]) : 32'hxxxx_xxxx, 32'h30 + 32'(i));
        wr(32'h8000_0001);
        idle();
        chk("clr_ovf_status", bus.mem_rdata, 32'h1000_0000);

        // Push on full in the same cycle as the pop
        frame_len = 3;
        set_stall(1'b1);
        sent.delete();
        for (int i = 0; i < 16; i++) wr(32'h60 + 32'(i));
        idle();
        chk("full2_status", bus.mem_rdata, 32'h2000_0010);
        set_stall(1'b0);
        wr(32'h0000_0070);
        idle();
        chk("push_pop_full_status", bus.mem_rdata, 32'hA000_0010);
        wait_empty(800);
        chk("push_pop_count", 32'(sent.size()), 32'd17);
        chk("push_pop_first", (sent.size() > 0) ? 32'(sent[0]) : 32'hxxxx_xxxx, 32'h60);
        chk("push_pop_last", (sent.size() == 17) ? 32'(sent[16]) : 32'hxxxx_xxxx, 32'h70);
        chk("push_pop_end_status", bus.mem_rdata, 32'h1000_0000);

        // Flush with five bytes queued mid-frame
        frame_len = 20;
        sent.delete();
        for (int i = 0; i < 6; i++) wr(32'h80 + 32'(i));
        idle();
        wr(32'h8000_0003);
        idle();
        chk("flush_status", bus.mem_rdata, 32'h9000_0000);
        wait_empty(100);
        chk("flush_sent_count", 32'(sent.size()), 32'd1);
        chk("flush_sent_byte", (sent.size() > 0) ? 32'(sent[0]) : 32'hxxxx_xxxx, 32'h80);

        // Reset while the serializer is mid-frame
        frame_len = 30;
        wr(32'h0000_0011);
        idle();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sent.delete();
        wr(32'h0000_0055);
        idle();
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #2;
            if (!bus.tx_active) break;
            n++;
        end
        chk("rst_mid_wait", 32'(n < 100), 32'd1);
        chk("rst_mid_dv", 32'(bus.tx_dv), 32'd1);
        chk("rst_mid_byte", 32'(bus.tx_byte), 32'h55);
        chk("rst_mid_sent", 32'(sent.size()), 32'd1);
        wait_empty(100);

        // Randomized traffic against the model
        rand_len = 1'b1;
        for (int it = 0; it < 1500; it++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 15) == 0) stall = ~stall;
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 45) begin
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = {1'b0, 23'($urandom), 8'($urandom)};
            end else if (r < 49) begin
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = {1'b1, 29'($urandom), 2'($urandom)};
            end else begin
                bus.mem_wen   = 1'b0;
                bus.mem_wdata = 32'($urandom);
            end
        end
        idle();
        set_stall(1'b0);
        wait_empty(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
